dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter AW, default 5, data memory word-address width.
REQ-002 Parameter DW, default 32, data word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0  input  1  requester 0 (CPU load/store port) transaction request.
REQ-006 we0  input  1  requester 0 write enable (1 = write, 0 = read).
REQ-007 addr0  input  AW  requester 0 word address.
REQ-008 wd0  input  DW  requester 0 write data.
REQ-009 ack0  output  1  requester 0 completion, one-cycle pulse.
REQ-010 rdata0  output  DW  requester 0 read data, valid while ack0=1.
REQ-011 req1, we1, addr1, wd1, ack1, rdata1: requester 1 (loader/debug port), same widths and meanings as requester 0.
REQ-012 addressDM  output  AW  address to DM.
REQ-013 wd  output  DW  write data to DM.
REQ-014 we  output  1  write enable to DM.
REQ-015 rd  input  DW  DM read data, combinational from addressDM.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The block SHALL implement the FSM IDLE -> GRANT -> RESP -> IDLE.
REQ-018 In IDLE with at least one reqN=1 at a rising edge: select a winner, latch its weN/addrN/wdN into addressDM/wd/internal we_q, record the winner, go to GRANT.
REQ-019 In IDLE with no request: remain in IDLE; outputs unchanged except we=0.
REQ-020 Arbitration: single requester wins directly; if req0=req1=1, the requester not served last wins (round-robin).
REQ-021 The last-served pointer SHALL update only on entry to GRANT.
REQ-022 we SHALL equal we_q during GRANT and 0 in IDLE and RESP, so each write is exactly one DM write cycle.
REQ-023 At the rising edge ending GRANT: for reads, capture rd into the winner's rdataN register; go to RESP.
REQ-024 In RESP: ackN=1 for the winner only; other ack=0; next state IDLE.
REQ-025 Latency: req sampled at edge k -> GRANT in cycle k+1 -> ackN in cycle k+2; one transaction per 3 cycles max.
REQ-026 Requesters SHALL hold reqN and fields stable until ackN; a requester holding reqN through ackN issues a new transaction, sampled in the following IDLE.
REQ-027 Dropping reqN after latch (GRANT/RESP) SHALL NOT abort: the transaction completes and ackN still pulses.
REQ-028 A request arriving during GRANT/RESP SHALL wait until IDLE; no request is lost while held.
REQ-029 rdataN for writes SHALL retain its prior value; rdataN holds between acks.
REQ-030 addressDM and wd SHALL retain the last latched values outside GRANT.
REQ-031 Under continuous req0=req1=1, grants SHALL strictly alternate (no starvation).

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, we=0, ack0=ack1=0, busy=0, addressDM=0, wd=0, rdata0=rdata1=0, last-served pointer=1 (requester 0 wins first tie).
REQ-033 Reset during GRANT SHALL drop we at once; the pending transaction is discarded with no ack.
REQ-034 After rst_n deasserts, the first request SHALL be sampled at the next rising edge.

Verification
REQ-035 Single write: req0=1, we0=1, addr0=3, wd0=A5A5A5A5 -> we=1 for one cycle with addressDM=3, wd=A5A5A5A5; ack0 two cycles after sampling.
REQ-036 Read-back: then req0=1, we0=0, addr0=3 -> ack0=1 with rdata0=A5A5A5A5; we stays 0.
REQ-037 Tie after reset: req0=req1=1 held, distinct addresses -> grant order 0,1,0,1; ack0/ack1 alternate every 3 cycles, never both high.
REQ-038 Contention: req1 asserted during requester 0's GRANT -> requester 1 granted in next IDLE; both acks delivered.
REQ-039 Reset mid-operation: rst_n=0 during a write GRANT -> we=0 and busy=0 immediately; no ack0; a subsequent read returns either old or new data consistently with DM write timing.
REQ-040 Abandoned request: req1 dropped during GRANT -> ack1 still pulses in RESP with valid rdata1.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Bundle of both requester ports plus the data-memory port of the arbiter.
// Latency: none, this is wiring only.
// Backpressure: requesters hold reqN and their fields until ackN.
interface dm_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    // requester 0 (CPU load/store port)
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wd0;
    logic          ack0;
    logic [DW-1:0] rdata0;
    // requester 1 (loader/debug port)
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wd1;
    logic          ack1;
    logic [DW-1:0] rdata1;
    // data memory side
    logic [AW-1:0] addressDM;
    logic [DW-1:0] wd;
    logic          we;
    logic [DW-1:0] rd;
    logic          busy;

    // arbiter view
    modport slave (
        input  req0, we0, addr0, wd0, req1, we1, addr1, wd1, rd,
        output ack0, rdata0, ack1, rdata1, addressDM, wd, we, busy
    );

    // environment view: both requesters and the memory
    modport master (
        output req0, we0, addr0, wd0, req1, we1, addr1, wd1, rd,
        input  ack0, rdata0, ack1, rdata1, addressDM, wd, we, busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Latency: request latched at an IDLE edge, one GRANT cycle, ack pulse in the following RESP cycle.
// Backpressure: a loser (or a request arriving while busy) simply waits; requests are never dropped.
module dm_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dm_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_winner;   // requester owning the current transaction
    logic          r_last;     // requester served most recently
    logic          r_we_q;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wd;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_any_req;
    logic          w_win;

    assign w_any_req = bus.req0 | bus.req1;
    // On a tie the requester not served last wins; otherwise the lone requester wins.
    assign w_win     = (bus.req0 && bus.req1) ? ~r_last : bus.req1;

    // State register; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: fixed IDLE -> GRANT -> RESP -> IDLE walk once a request is taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_GRANT;
            S_GRANT: w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Latch the winner's command on entry to GRANT; capture read data when GRANT ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winner <= 1'b0;
            r_last   <= 1'b1;   // requester 0 takes the first tie
            r_we_q   <= 1'b0;
            r_addr   <= '0;
            r_wd     <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_winner <= w_win;
                r_last   <= w_win;
                r_we_q   <= w_win ? bus.we1   : bus.we0;
                r_addr   <= w_win ? bus.addr1 : bus.addr0;
                r_wd     <= w_win ? bus.wd1   : bus.wd0;
            end
            if (r_state == S_GRANT && !r_we_q) begin
                if (r_winner) r_rdata1 <= bus.rd;
                else          r_rdata0 <= bus.rd;
            end
        end
    end

    // Strobes decode straight from state so reset removes them immediately.
    assign bus.we        = (r_state == S_GRANT) && r_we_q;
    assign bus.ack0      = (r_state == S_RESP) && !r_winner;
    assign bus.ack1      = (r_state == S_RESP) &&  r_winner;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.addressDM = r_addr;
    assign bus.wd        = r_wd;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dm_arbiter_if #(.AW(5), .DW(32)) bus ();

    dm_arbiter #(.AW(5), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // data memory: combinational read, write on rising edge
    logic [31:0] mem [32] = '{default: '0};
    assign bus.rd = mem[bus.addressDM];
    always @(posedge clk) if (bus.we) mem[bus.addressDM] <= bus.wd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
        checks++; if (bus.we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", bus.we); end
        checks++; if ({bus.ack0, bus.ack1} !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", {bus.ack0, bus.ack1}); end
        checks++; if (bus.addressDM !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", bus.addressDM); end
        checks++; if (bus.wd !== 32'd0) begin failures++; $display("FAIL reset_wd got=%0h exp=0", bus.wd); end
        checks++; if ({bus.rdata0, bus.rdata1} !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", {bus.rdata0, bus.rdata1}); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd3; bus.wd0 = 32'hA5A5A5A5;
        tick(); // GRANT
        checks++; if (bus.we !== 1'b1) begin failures++; $display("FAIL write_we got=%0h exp=1", bus.we); end
        checks++; if (bus.addressDM !== 5'd3) begin failures++; $display("FAIL write_addr got=%0h exp=3", bus.addressDM); end
        checks++; if (bus.wd !== 32'hA5A5A5A5) begin failures++; $display("FAIL write_wd got=%0h exp=a5a5a5a5", bus.wd); end
        checks++; if ({bus.busy, bus.ack0} !== 2'b10) begin failures++; $display("FAIL write_grant_busy_ack got=%b exp=10", {bus.busy, bus.ack0}); end
        tick(); // RESP
        checks++; if (bus.we !== 1'b0) begin failures++; $display("FAIL write_we_resp got=%0h exp=0", bus.we); end
        checks++; if ({bus.ack0, bus.ack1} !== 2'b10) begin failures++; $display("FAIL write_ack got=%b exp=10", {bus.ack0, bus.ack1}); end
        bus.req0 = 1'b0; bus.we0 = 1'b0;
        tick(); // IDLE
        checks++; if ({bus.busy, bus.ack0, bus.we} !== 3'b000) begin failures++; $display("FAIL write_idle got=%b exp=000", {bus.busy, bus.ack0, bus.we}); end
        checks++; if (bus.addressDM !== 5'd3 || bus.wd !== 32'hA5A5A5A5) begin failures++; $display("FAIL write_hold got=%0h/%0h exp=3/a5a5a5a5", bus.addressDM, bus.wd); end
        checks++; if (mem[3] !== 32'hA5A5A5A5) begin failures++; $display("FAIL write_mem got=%0h exp=a5a5a5a5", mem[3]); end
    endtask

    task automatic test_readback();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd3; bus.wd0 = 32'h0;
        tick(); // GRANT
        checks++; if ({bus.we, bus.busy} !== 2'b01) begin failures++; $display("FAIL rd_grant got=%b exp=01", {bus.we, bus.busy}); end
        tick(); // RESP
        checks++; if (bus.ack0 !== 1'b1) begin failures++; $display("FAIL rd_ack got=%0h exp=1", bus.ack0); end
        checks++; if (bus.rdata0 !== 32'hA5A5A5A5) begin failures++; $display("FAIL rd_data got=%0h exp=a5a5a5a5", bus.rdata0); end
        bus.req0 = 1'b0;
        tick(); tick();
        checks++; if (bus.rdata0 !== 32'hA5A5A5A5 || bus.busy !== 1'b0) begin failures++; $display("FAIL rd_hold got=%0h busy=%0h exp=a5a5a5a5 busy=0", bus.rdata0, bus.busy); end
    endtask

    task automatic test_contention();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd5; bus.wd0 = 32'hDEADBEEF;
        tick(); // GRANT for requester 0
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd5; bus.wd1 = 32'h0;
        tick(); // RESP for requester 0
        checks++; if ({bus.ack0, bus.ack1} !== 2'b10) begin failures++; $display("FAIL cont_ack0 got=%b exp=10", {bus.ack0, bus.ack1}); end
        bus.req0 = 1'b0; bus.we0 = 1'b0;
        tick(); // IDLE, samples req1
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cont_idle got=%0h exp=0", bus.busy); end
        tick(); // GRANT for requester 1
        checks++; if (bus.addressDM !== 5'd5 || bus.busy !== 1'b1) begin failures++; $display("FAIL cont_grant1 got=%0h busy=%0h exp=5 busy=1", bus.addressDM, bus.busy); end
        tick(); // RESP for requester 1
        checks++; if ({bus.ack0, bus.ack1} !== 2'b01) begin failures++; $display("FAIL cont_ack1 got=%b exp=01", {bus.ack0, bus.ack1}); end
        checks++; if (bus.rdata1 !== 32'hDEADBEEF) begin failures++; $display("FAIL cont_rdata1 got=%0h exp=deadbeef", bus.rdata1); end
        bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        logic [4:0]  exp_addr [2];
        logic [31:0] exp_data [2];
        exp_addr[0] = 5'd3; exp_data[0] = 32'hA5A5A5A5;
        exp_addr[1] = 5'd5; exp_data[1] = 32'hDEADBEEF;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd3;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd5;
        for (int k = 0; k < 4; k++) begin
            tick(); // GRANT
            checks++; if (bus.addressDM !== exp_addr[k%2]) begin failures++; $display("FAIL tie_grant%0d got=%0h exp=%0h", k, bus.addressDM, exp_addr[k%2]); end
            tick(); // RESP
            checks++; if ({bus.ack0, bus.ack1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL tie_ack%0d got=%b exp=%b", k, {bus.ack0, bus.ack1}, (k % 2 == 0) ? 2'b10 : 2'b01); end
            checks++; if (((k % 2 == 0) ? bus.rdata0 : bus.rdata1) !== exp_data[k%2]) begin failures++; $display("FAIL tie_rdata%0d got=%0h exp=%0h", k, (k % 2 == 0) ? bus.rdata0 : bus.rdata1, exp_data[k%2]); end
            if (k == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
            tick(); // IDLE
            checks++; if ({bus.busy, bus.ack0, bus.ack1} !== 3'b000) begin failures++; $display("FAIL tie_idle%0d got=%b exp=000", k, {bus.busy, bus.ack0, bus.ack1}); end
        end
    endtask

    task automatic test_abandon();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd3;
        tick(); // GRANT
        bus.req1 = 1'b0;
        tick(); // RESP
        checks++; if (bus.ack1 !== 1'b1) begin failures++; $display("FAIL aband_ack1 got=%0h exp=1", bus.ack1); end
        checks++; if (bus.rdata1 !== 32'hA5A5A5A5) begin failures++; $display("FAIL aband_rdata1 got=%0h exp=a5a5a5a5", bus.rdata1); end
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL aband_idle got=%0h exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd3; bus.wd0 = 32'h12345678;
        tick(); // GRANT
        checks++; if (bus.we !== 1'b1) begin failures++; $display("FAIL rmid_we_pre got=%0h exp=1", bus.we); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({bus.we, bus.busy} !== 2'b00) begin failures++; $display("FAIL rmid_drop got=%b exp=00", {bus.we, bus.busy}); end
        bus.req0 = 1'b0; bus.we0 = 1'b0;
        tick();
        checks++; if (bus.ack0 !== 1'b0) begin failures++; $display("FAIL rmid_noack got=%0h exp=0", bus.ack0); end
        checks++; if (mem[3] !== 32'hA5A5A5A5) begin failures++; $display("FAIL rmid_mem got=%0h exp=a5a5a5a5", mem[3]); end
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.addr0 = 5'd3;
        tick(); // GRANT
        tick(); // RESP
        checks++; if (bus.ack0 !== 1'b1 || bus.rdata0 !== 32'hA5A5A5A5) begin failures++; $display("FAIL rmid_read got=ack%0h/%0h exp=ack1/a5a5a5a5", bus.ack0, bus.rdata0); end
        bus.req0 = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wd0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wd1 = '0;
        test_reset();
        test_write();
        test_readback();
        test_contention();
        test_tie();
        test_abandon();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
